// File: rtl/bcd_pkg.sv
// bcd_pkg: packed-BCD price type shared by the order-book blocks
package bcd_pkg;
   localparam int PRICE_DIGITS = 4;
   typedef logic [4*PRICE_DIGITS-1:0] price_t;
endpackage

// File: rtl/ob_pkg.sv
// ob_pkg: order-book quantity types plus the table-query sequencer types
package ob_pkg;
   localparam int QUANTITY_W = 16;
   localparam int ACCUM_QUANTITY_W = 24;
   localparam int QRY_TIMEOUT_N_DEFAULT = 64;
   typedef logic [QUANTITY_W-1:0] quantity_t;
   typedef logic [ACCUM_QUANTITY_W-1:0] accum_quantity_t;
   typedef enum logic [1:0] {QRY_IDLE, QRY_ISSUE, QRY_WAIT, QRY_RESP} qry_fsm_state_t;
   typedef struct packed {
      bcd_pkg::price_t price;
      quantity_t quantity;
   } qry_req_t;
   typedef struct packed {
      logic fill;
      logic err;
      accum_quantity_t avail;
   } qry_rsp_t;
   function automatic logic qry_fill(accum_quantity_t avail, quantity_t required);
      return avail >= accum_quantity_t'(required);
   endfunction
endpackage

// File: rtl/ob_qry_wdog.sv
// ob_qry_wdog: loadable up-counter flagging the last permitted wait cycle
module ob_qry_wdog #(
   parameter int TIMEOUT_N = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic tc
);
   localparam int W = $clog2(TIMEOUT_N);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk)
      if (!rst_n || load) cnt_q <= '0;
      else if (en && !tc) cnt_q <= cnt_q + 1'b1;
   assign tc = cnt_q == W'(TIMEOUT_N - 1);
endmodule

// File: rtl/ob_table_qry.sv
// ob_table_qry: sequences one fill-qualification query through the table count engine
module ob_table_qry
   import ob_pkg::*;
#(
   parameter logic is_ask = 1'b1,
   parameter int TIMEOUT_N = QRY_TIMEOUT_N_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_vld,
   output logic req_rdy,
   input  bcd_pkg::price_t req_price,
   input  quantity_t req_quantity,
   output logic cnt_cmd_vld,
   output bcd_pkg::price_t cnt_cmd_price,
   input  accum_quantity_t cnt_rsp_quantity,
   input  logic cnt_busy,
   output logic rsp_vld,
   input  logic rsp_rdy,
   output logic rsp_fill,
   output accum_quantity_t rsp_avail,
   output logic rsp_err,
   output logic busy
);
   qry_fsm_state_t state_q, state_d;
   qry_req_t req_q;
   qry_rsp_t rsp_q, rsp_d;
   logic cmd_d, wdog_tc;
   ob_qry_wdog #(.TIMEOUT_N(TIMEOUT_N)) u_wdog (
      .clk(clk),
      .rst_n(rst_n),
      .load(state_q == QRY_ISSUE && cnt_cmd_vld),
      .en(state_q == QRY_WAIT),
      .tc(wdog_tc)
   );
   // The command strobe is a flop, so the engine-idle decision is taken one cycle ahead.
   always_comb begin
      state_d = state_q;
      cmd_d = 1'b0;
      rsp_d = rsp_q;
      case (state_q)
         QRY_IDLE:
            if (req_vld && req_quantity == '0) begin
               state_d = QRY_RESP;
               rsp_d = '{fill: 1'b1, err: 1'b0, avail: '0};
            end else if (req_vld) begin
               state_d = QRY_ISSUE;
               cmd_d = ~cnt_busy;
            end
         QRY_ISSUE:
            if (cnt_cmd_vld) state_d = QRY_WAIT;
            else cmd_d = ~cnt_busy;
         QRY_WAIT:
            if (!cnt_busy) begin
               state_d = QRY_RESP;
               rsp_d = '{fill: qry_fill(cnt_rsp_quantity, req_q.quantity), err: 1'b0, avail: cnt_rsp_quantity};
            end else if (wdog_tc) begin
               state_d = QRY_RESP;
               rsp_d = '{fill: 1'b0, err: 1'b1, avail: '0};
            end
         QRY_RESP:
            if (rsp_rdy) state_d = QRY_IDLE;
         default: state_d = QRY_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= QRY_IDLE;
         req_q <= '0;
         rsp_q <= '0;
         cnt_cmd_vld <= 1'b0;
         req_rdy <= 1'b1;
         rsp_vld <= 1'b0;
         busy <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == QRY_IDLE && req_vld) req_q <= '{price: req_price, quantity: req_quantity};
         rsp_q <= rsp_d;
         cnt_cmd_vld <= cmd_d;
         req_rdy <= state_d == QRY_IDLE;
         rsp_vld <= state_d == QRY_RESP;
         busy <= state_d != QRY_IDLE;
      end
   end
   assign cnt_cmd_price = req_q.price;
   assign rsp_fill = rsp_q.fill;
   assign rsp_err = rsp_q.err;
   assign rsp_avail = rsp_q.avail;
   if (is_ask) begin : g_ask_chk
      assert property (@(posedge clk) disable iff (!rst_n) cnt_cmd_vld |-> state_q == QRY_ISSUE);
   end
endmodule

// File: tb/tb_ob_table_qry.sv
// tb_ob_table_qry: scoreboard bench driving ob_table_qry against a count-engine stub
module tb_ob_table_qry;
   import ob_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req_vld = 1'b0;
   logic req_rdy;
   logic [15:0] req_price = '0;
   logic [15:0] req_quantity = '0;
   logic cnt_cmd_vld;
   logic [15:0] cnt_cmd_price;
   logic [23:0] cnt_rsp_quantity;
   logic cnt_busy;
   logic rsp_vld;
   logic rsp_rdy = 1'b0;
   logic rsp_fill;
   logic [23:0] rsp_avail;
   logic rsp_err;
   logic busy;
   int stub_lat = 3;
   logic [23:0] stub_result = '0;
   logic stub_hang = 1'b0;
   logic ext_busy = 1'b0;
   int busy_cnt;
   logic hang_act;
   int cmd_cnt = 0;
   int cmd_bad = 0;
   logic [15:0] cmd_price_seen = '0;
   qry_rsp_t sb_q[$];
   int n_checks = 0;
   int n_errors = 0;
   always #5 clk = ~clk;
   ob_table_qry #(.is_ask(1'b1), .TIMEOUT_N(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
      .req_price(req_price), .req_quantity(req_quantity),
      .cnt_cmd_vld(cnt_cmd_vld), .cnt_cmd_price(cnt_cmd_price),
      .cnt_rsp_quantity(cnt_rsp_quantity), .cnt_busy(cnt_busy),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_fill(rsp_fill),
      .rsp_avail(rsp_avail), .rsp_err(rsp_err), .busy(busy)
   );
   // engine stub: busy for stub_lat cycles after a command, or forever in hang mode
   always @(posedge clk) begin
      if (!rst_n) begin
         busy_cnt <= 0;
         hang_act <= 1'b0;
      end else if (cnt_cmd_vld) begin
         busy_cnt <= stub_lat;
         hang_act <= stub_hang;
      end else begin
         if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
         if (!stub_hang) hang_act <= 1'b0;
      end
   end
   assign cnt_busy = ext_busy | (busy_cnt != 0) | hang_act;
   assign cnt_rsp_quantity = stub_result;
   always @(negedge clk) begin
      if (cnt_cmd_vld) begin
         cmd_cnt++;
         cmd_price_seen = cnt_cmd_price;
         if (cnt_busy) cmd_bad++;
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic run_query(input logic [15:0] price, input logic [15:0] qty, input int exp_lat, input int hold);
      qry_rsp_t e;
      int lat;
      int c0;
      c0 = cmd_cnt;
      e.fill = (qty == 0) ? 1'b1 : stub_hang ? 1'b0 : (stub_result >= {8'd0, qty});
      e.err = (qty != 0) && stub_hang;
      e.avail = (qty == 0 || stub_hang) ? 24'd0 : stub_result;
      sb_q.push_back(e);
      lat = 0;
      while (!req_rdy && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("req_rdy_idle", req_rdy, 1);
      req_vld = 1'b1;
      req_price = price;
      req_quantity = qty;
      @(negedge clk);
      req_vld = 1'b0;
      lat = 1;
      while (!rsp_vld && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("rsp_vld_seen", rsp_vld, 1);
      if (exp_lat > 0) check("latency", lat, exp_lat);
      e = sb_q.pop_front();
      for (int i = 0; i <= hold; i++) begin
         check("rsp_fill", rsp_fill, e.fill);
         check("rsp_err", rsp_err, e.err);
         check("rsp_avail", rsp_avail, e.avail);
         if (i < hold) begin
            req_vld = 1'b1;
            req_price = 16'h9999;
            req_quantity = 16'd7;
            @(negedge clk);
            check("hold_req_rdy", req_rdy, 0);
            check("hold_rsp_vld", rsp_vld, 1);
         end
      end
      req_vld = 1'b0;
      rsp_rdy = 1'b1;
      @(negedge clk);
      rsp_rdy = 1'b0;
      check("rsp_vld_drop", rsp_vld, 0);
      check("req_rdy_back", req_rdy, 1);
      check("cmd_pulses", cmd_cnt - c0, (qty != 0) ? 1 : 0);
      if (qty != 0) check("cmd_price", cmd_price_seen, price);
   endtask
   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_rdy"}, req_rdy, 1);
      check({tag, "_cmd_vld"}, cnt_cmd_vld, 0);
      check({tag, "_rsp_vld"}, rsp_vld, 0);
      check({tag, "_fill"}, rsp_fill, 0);
      check({tag, "_err"}, rsp_err, 0);
      check({tag, "_avail"}, rsp_avail, 0);
      check({tag, "_busy"}, busy, 0);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      stub_result = 24'd150;
      run_query(16'h1005, 16'd100, 6, 0);
      stub_result = 24'd99;
      run_query(16'h1005, 16'd100, 6, 0);
      stub_result = 24'd100;
      run_query(16'h1010, 16'd100, 6, 0);
      run_query(16'h1020, 16'd0, 1, 0);
      stub_lat = 0;
      stub_result = 24'd500;
      run_query(16'h0995, 16'd10, 3, 0);
      stub_lat = 3;
      stub_result = 24'd40;
      ext_busy = 1'b1;
      fork
         run_query(16'h2050, 16'd20, -1, 0);
         begin
            repeat (5) @(negedge clk);
            ext_busy = 1'b0;
         end
      join
      check("cmd_while_busy", cmd_bad, 0);
      stub_hang = 1'b1;
      run_query(16'h3000, 16'd5, 10, 0);
      stub_hang = 1'b0;
      @(negedge clk);
      stub_result = 24'd150;
      run_query(16'h3001, 16'd150, 6, 0);
      run_query(16'h4000, 16'd50, 6, 4);
      req_vld = 1'b1;
      req_price = 16'h5000;
      req_quantity = 16'd30;
      @(negedge clk);
      req_vld = 1'b0;
      @(negedge clk);
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      stub_result = 24'd12;
      run_query(16'h5001, 16'd13, 6, 0);
      check("cmd_while_busy_end", cmd_bad, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
